// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, full flag set and an optional
// multi-cycle shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             flag_ovf,
  output logic             flag_illegal
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_NOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_ASR = 4'd8, OP_MUL = 4'd9
  } op_e;

  typedef enum logic {IDLE, MUL} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry;
    logic             neg;
    logic             ovf;
    logic             illegal;
  } out_t;

  state_e          state;
  logic [SW-1:0]   cnt;
  out_t            out_q;
  out_t            alu_pkt;
  out_t            mul_pkt;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;

  logic          accept;
  logic          is_mul;
  logic [SW-1:0] sh;
  logic [WIDTH:0] sum, diff, shl_x, shr_x, asr_x;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (opcode == OP_MUL) && MUL_EN;

  // Shifts run on a one-bit-extended operand so the last bit shifted out
  // lands in the extra position (and stays 0 for a zero shift).
  assign sh    = b[SW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shl_x = {1'b0, a} << sh;
  assign shr_x = {a, 1'b0} >> sh;
  assign asr_x = $signed({a, 1'b0}) >>> sh;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    alu_pkt = '0;
    unique case (opcode)
      OP_ADD: begin
        alu_pkt.res   = sum[WIDTH-1:0];
        alu_pkt.carry = sum[WIDTH];
        alu_pkt.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_pkt.res   = diff[WIDTH-1:0];
        alu_pkt.carry = diff[WIDTH];
        alu_pkt.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_pkt.res = a & b;
      OP_OR:  alu_pkt.res = a | b;
      OP_XOR: alu_pkt.res = a ^ b;
      OP_NOR: alu_pkt.res = ~(a | b);
      OP_SHL: begin
        alu_pkt.res   = shl_x[WIDTH-1:0];
        alu_pkt.carry = shl_x[WIDTH];
      end
      OP_SHR: begin
        alu_pkt.res   = shr_x[WIDTH:1];
        alu_pkt.carry = shr_x[0];
      end
      OP_ASR: begin
        alu_pkt.res   = asr_x[WIDTH:1];
        alu_pkt.carry = asr_x[0];
      end
      OP_MUL:  alu_pkt.illegal = !MUL_EN;
      default: alu_pkt.illegal = 1'b1;
    endcase
    alu_pkt.zero = (alu_pkt.res == '0);
    alu_pkt.neg  = alu_pkt.res[WIDTH-1];
  end

  // One partial product per cycle; the final iteration's sum is the product.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    mul_pkt       = '0;
    mul_pkt.res   = acc_next[WIDTH-1:0];
    mul_pkt.carry = |acc_next[2*WIDTH-1:WIDTH];
    mul_pkt.zero  = (acc_next[WIDTH-1:0] == '0);
    mul_pkt.neg   = acc_next[WIDTH-1];
  end

  // NOTE: multiplier datapath registers carry no reset; they are always
  // loaded on MUL accept before being read.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      // NOTE: the drain clear comes first so a result written later in this
      // block on the same edge overrides it (last non-blocking write wins).
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= MUL;
              cnt   <= '0;
            end else begin
              out_q     <= alu_pkt;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          cnt <= cnt + SW'(1);
          if (cnt == SW'(WIDTH - 1)) begin
            out_q     <= mul_pkt;
            out_valid <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result       = out_q.res;
  assign flag_zero    = out_q.zero;
  assign flag_carry   = out_q.carry;
  assign flag_neg     = out_q.neg;
  assign flag_ovf     = out_q.ovf;
  assign flag_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed test-plan cases plus a
// scoreboard fed by an independent reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [3:0] opcode = '0;
  logic       in_ready, out_valid;
  logic [7:0] result;
  logic       flag_zero, flag_carry, flag_neg, flag_ovf, flag_illegal;

  logic       n_in_valid = 1'b0;
  logic       n_out_ready = 1'b1;
  logic [7:0] n_a = '0, n_b = '0;
  logic [3:0] n_opcode = '0;
  logic       n_in_ready, n_out_valid;
  logic [7:0] n_result;
  logic       n_zero, n_carry, n_neg, n_ovf, n_illegal;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_neg(flag_neg), .flag_ovf(flag_ovf), .flag_illegal(flag_illegal)
  );

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) u_nomul (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .opcode(n_opcode), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .flag_zero(n_zero), .flag_carry(n_carry),
    .flag_neg(n_neg), .flag_ovf(n_ovf), .flag_illegal(n_illegal)
  );

  // Packed view {illegal, ovf, neg, carry, zero, result[7:0]}.
  logic [12:0] obs, n_obs;
  assign obs   = {flag_illegal, flag_ovf, flag_neg, flag_carry, flag_zero, result};
  assign n_obs = {n_illegal, n_ovf, n_neg, n_carry, n_zero, n_result};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rand_done = 1'b0;
  logic [12:0] sb_q[$];
  int out_times[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [3:0] op, input bit mul_en);
    int sx, sy, s, p;
    logic [7:0] r, t;
    logic c, v, il;
    sx = (x > 8'd127) ? int'(x) - 256 : int'(x);
    sy = (y > 8'd127) ? int'(y) - 256 : int'(y);
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0; t = x;
    case (op)
      4'd0: begin p = int'(x) + int'(y); r = p[7:0]; c = (p > 255); s = sx + sy; v = (s > 127) || (s < -128); end
      4'd1: begin p = int'(x) - int'(y); r = p[7:0]; c = (x < y);   s = sx - sy; v = (s > 127) || (s < -128); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~(x | y);
      4'd6: begin repeat (int'(y[2:0])) begin c = t[7]; t = {t[6:0], 1'b0}; end r = t; end
      4'd7: begin repeat (int'(y[2:0])) begin c = t[0]; t = {1'b0, t[7:1]}; end r = t; end
      4'd8: begin repeat (int'(y[2:0])) begin c = t[0]; t = {t[7], t[7:1]}; end r = t; end
      4'd9: begin
        if (mul_en) begin p = int'(x) * int'(y); r = p[7:0]; c = (p > 255); end
        else il = 1'b1;
      end
      default: il = 1'b1;
    endcase
    return {il, v, r[7], c, (r == 8'd0), r};
  endfunction

  // Scoreboard: push on transfer-in, pop/compare on transfer-out.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_spurious_out", sb_q.size(), 1);
        else check("sb", obs, sb_q.pop_front());
        out_times.push_back(cyc);
      end
      if (in_valid && in_ready) sb_q.push_back(model(a, b, opcode, 1'b1));
    end
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top);
    int waited = 0;
    a = ta; b = tb; opcode = top; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid rises.
  task automatic wait_out(output int edges, output bit saw_ready);
    edges = 0;
    saw_ready = 1'b0;
    while (!out_valid && edges < 50) begin
      saw_ready |= in_ready;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic [3:0] top, input logic [12:0] exp, input int exp_edges);
    int edges;
    bit saw_ready;
    send(ta, tb, top);
    wait_out(edges, saw_ready);
    check({tag, "_out"}, obs, exp);
    check({tag, "_edges"}, edges, exp_edges);
    if (exp_edges > 0) check({tag, "_busy_ready"}, saw_ready, 0);
  endtask

  initial begin
    int drain;
    bit seen_valid;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", obs, 13'h000);
    check("rst_in_ready", in_ready, 1);

    run("add_basic", 8'h08, 8'h04, 4'd0, 13'h00C, 0);
    run("add_ovf",   8'h7F, 8'h01, 4'd0, 13'hC80, 0);
    run("add_carry", 8'hFF, 8'h01, 4'd0, 13'h300, 0);
    run("sub_borrow", 8'h04, 8'h08, 4'd1, 13'h6FC, 0);
    run("mul_13x11", 8'd13, 8'd11, 4'd9, 13'h48F, 8);
    run("mul_hi",    8'h20, 8'h10, 4'd9, 13'h300, 8);
    run("illegal_f", 8'h12, 8'h34, 4'd15, 13'h1100, 0);
    run("shl_81",    8'h81, 8'h01, 4'd6, 13'h202, 0);
    run("asr_80",    8'h80, 8'h07, 4'd8, 13'h4FF, 0);

    n_a = 8'd3; n_b = 8'd4; n_opcode = 4'd9; n_in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    check("nomul_valid", n_out_valid, 1);
    check("nomul_out", n_obs, 13'h1100);

    // Backpressure: result held, nothing new accepted until drain.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'd1, 8'd2, 4'd0);
    check("bp_valid", out_valid, 1);
    a = 8'd5; b = 8'd5; opcode = 4'd0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_hold", obs, 13'h003);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_up", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_new_valid", out_valid, 1);
    check("bp_new", obs, 13'h00A);

    repeat (2) @(posedge clk);
    #1;
    out_times.delete();
    for (int i = 0; i < 5; i++) send(8'(i * 3), 8'(i + 1), 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", out_times.size(), 5);
    for (int i = 1; i < out_times.size(); i++)
      check("stream_gap", out_times[i] - out_times[i-1], 1);

    // Reset on the 4th MUL iteration aborts the operation.
    send(8'd13, 8'd11, 4'd9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    seen_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen_valid |= out_valid;
    end
    check("abort_no_result", seen_valid, 0);

    fork
      begin
        for (int i = 0; i < 150; i++) send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain = 0;
    while (sb_q.size() != 0 && drain < 100) begin
      @(posedge clk);
      #1;
      drain++;
    end
    check("drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
